// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the BCD scan counter:
//   bcd_t         one 4-bit BCD digit
//   BCD_MAX       largest legal digit value (9)
//   BCD_ZERO      zero digit
//   BCD_BLANK     code the downstream 7-segment decoder renders as blank
//   bcd_sanitize  maps an illegal digit (>9) to 0
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX   = 4'd9;
  localparam bcd_t BCD_ZERO  = 4'd0;
  localparam bcd_t BCD_BLANK = 4'hF;

  function automatic bcd_t bcd_sanitize(input bcd_t d);
    return (d > BCD_MAX) ? BCD_ZERO : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One decade of the BCD up/down counter. Steps when step_in is high and
// forwards a step (carry or borrow) to the next decade in the same cycle.
// Ports:
//   CLK       clock, rising edge
//   RST_N     asynchronous active-low reset, clears the digit
//   LOAD      synchronous load of LD (illegal digits stored as 0)
//   LD        load value for this digit
//   step_in   step request from the lower decade (or count enable for digit 0)
//   UP        1 = increment, 0 = decrement
//   Q         registered digit value
//   step_out  carry/borrow into the next decade
// ---------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic LOAD,
  input  bcd_t LD,
  input  logic step_in,
  input  logic UP,
  output bcd_t Q,
  output logic step_out
);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (LOAD) begin
      q_d = bcd_sanitize(LD);
    end else if (step_in) begin
      if (UP) begin
        // >= rather than == so the digit can never leave 0..9
        q_d = (q_q >= BCD_MAX) ? BCD_ZERO : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_ZERO || q_q > BCD_MAX) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q <= BCD_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q        = q_q;
  assign step_out = step_in & (UP ? (q_q == BCD_MAX) : (q_q == BCD_ZERO));

endmodule

// File: rtl/bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// bcd_scan_counter
// NDIG-digit BCD up/down counter with a time-multiplexed display scanner.
// Each digit is shown on BCD_OUT for SCAN_DIV clock cycles with a one-hot
// DIG_SEL strobe, feeding a BCD-to-7-segment decoder.
// Parameters:
//   NDIG      number of digits (1..8), digit 0 least significant
//   SCAN_DIV  cycles each digit is shown (>=1)
// Ports:
//   CLK       clock, rising edge
//   RST_N     asynchronous active-low reset
//   EN        count enable, one step per cycle
//   UP        1 = increment, 0 = decrement
//   LOAD      synchronous parallel load (priority over EN)
//   LD_VAL    packed BCD load value, digit i = [4i+3:4i]
//   COUNT     registered packed BCD count
//   CARRY     one-cycle pulse after a full wrap (up or down)
//   BCD_OUT   code of the scanned digit
//   DIG_SEL   one-hot select of the scanned digit
// Build option:
//   BCD_BLANK_EN  when defined, leading zeros (never digit 0) are driven as
//                 BCD_BLANK on BCD_OUT; COUNT is unaffected.
// ---------------------------------------------------------------------------
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              UP,
  input  logic              LOAD,
  input  logic [4*NDIG-1:0] LD_VAL,
  output logic [4*NDIG-1:0] COUNT,
  output logic              CARRY,
  output logic [3:0]        BCD_OUT,
  output logic [NDIG-1:0]   DIG_SEL
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  // ---------------------------------------------------------------------
  // Counter: ripple step chain through the digits
  // ---------------------------------------------------------------------
  logic [NDIG:0] step;
  bcd_t          digit_q [NDIG];

  // LOAD masks the chain so a load never counts or raises CARRY
  assign step[0] = EN & ~LOAD;

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit u_digit (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .LOAD     (LOAD),
      .LD       (bcd_t'(LD_VAL[4*g +: 4])),
      .step_in  (step[g]),
      .UP       (UP),
      .Q        (digit_q[g]),
      .step_out (step[g+1])
    );
    assign COUNT[4*g +: 4] = digit_q[g];
  end

  // A step leaving the top digit means every digit wrapped
  logic carry_q;
  logic carry_d;

  assign carry_d = step[NDIG];

  // ---------------------------------------------------------------------
  // Scanner: free-running prescaler and digit index
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             scan_tick;

  assign scan_tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (scan_tick) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      carry_q <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
    end else begin
      carry_q <= carry_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
    end
  end

  assign CARRY = carry_q;

  // ---------------------------------------------------------------------
  // Output mux (registers only, no input-to-output path)
  // ---------------------------------------------------------------------
  bcd_t            sel_digit;
  logic [NDIG-1:0] dig_sel;
  logic            blank_sel;

  always_comb begin
    sel_digit = BCD_ZERO;
    dig_sel   = '0;
    for (int j = 0; j < NDIG; j++) begin
      if (idx_q == IDX_W'(j)) begin
        sel_digit  = digit_q[j];
        dig_sel[j] = 1'b1;
      end
    end
  end

`ifdef BCD_BLANK_EN
  // Blank when the scanned digit and everything above it are zero.
  // Digit 0 is exempt so a zero count still shows a single "0".
  logic upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < NDIG; j++) begin
      if ((IDX_W'(j) >= idx_q) && (digit_q[j] != BCD_ZERO)) begin
        upper_zero = 1'b0;
      end
    end
    blank_sel = upper_zero && (idx_q != '0);
  end
`else
  assign blank_sel = 1'b0;
`endif

  assign BCD_OUT = blank_sel ? BCD_BLANK : sel_digit;
  assign DIG_SEL = dig_sel;

endmodule
